// File: rtl/registrador_id_ex_if.sv
// ID/EX boundary bundle: decode-side inputs, flush request, and the
// registered EX-side operands/controls plus hazard/debug outputs.
interface registrador_id_ex_if #(
  parameter int LARGURA_DADO = 32,
  parameter int LARGURA_CONT = 16
);
  logic [LARGURA_DADO-1:0] PC4_ID, dado1_ID, dado2_ID, endereco_ID;
  logic [4:0]              rs_ID, rt_ID, rd_ID;
  logic                    valido_ID;
  logic                    RegDest_ID, ALUSrc_ID, MemRead_ID, MemWrite_ID;
  logic                    RegWrite_ID, MemtoReg_ID, Branch_ID;
  logic [1:0]              ALUOp_ID;
  logic                    flush;

  logic [LARGURA_DADO-1:0] PC4, dado1ALU, dado2ALU, endereco;
  logic [4:0]              reg2, reg3, rs_EX;
  logic [5:0]              functEx;
  logic [1:0]              ALUOpEx;
  logic                    regDestEx, ALUSrc_EX, MemRead_EX, MemWrite_EX;
  logic                    RegWrite_EX, MemtoReg_EX, Branch_EX, valido_EX;
  logic                    stall;
  logic [LARGURA_CONT-1:0] num_bolhas, num_descartes;

  modport slave (
    input  PC4_ID, dado1_ID, dado2_ID, endereco_ID, rs_ID, rt_ID, rd_ID,
           valido_ID, RegDest_ID, ALUSrc_ID, MemRead_ID, MemWrite_ID,
           RegWrite_ID, MemtoReg_ID, Branch_ID, ALUOp_ID, flush,
    output PC4, dado1ALU, dado2ALU, endereco, reg2, reg3, rs_EX, functEx,
           ALUOpEx, regDestEx, ALUSrc_EX, MemRead_EX, MemWrite_EX,
           RegWrite_EX, MemtoReg_EX, Branch_EX, valido_EX, stall,
           num_bolhas, num_descartes
  );

  modport master (
    output PC4_ID, dado1_ID, dado2_ID, endereco_ID, rs_ID, rt_ID, rd_ID,
           valido_ID, RegDest_ID, ALUSrc_ID, MemRead_ID, MemWrite_ID,
           RegWrite_ID, MemtoReg_ID, Branch_ID, ALUOp_ID, flush,
    input  PC4, dado1ALU, dado2ALU, endereco, reg2, reg3, rs_EX, functEx,
           ALUOpEx, regDestEx, ALUSrc_EX, MemRead_EX, MemWrite_EX,
           RegWrite_EX, MemtoReg_EX, Branch_EX, valido_EX, stall,
           num_bolhas, num_descartes
  );
endinterface

// File: rtl/registrador_id_ex.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// on hazard or flush, and saturating bubble/flush debug counters.
module registrador_id_ex #(
  parameter int LARGURA_DADO = 32,
  parameter int LARGURA_CONT = 16
) (
  input logic                 clock,
  input logic                 reset,
  registrador_id_ex_if.slave  idEx
);

  typedef struct packed {
    logic       regDest;
    logic       aluSrc;
    logic       memRead;
    logic       memWrite;
    logic       regWrite;
    logic       memToReg;
    logic       branch;
    logic [1:0] aluOp;
  } ctrl_t;

  localparam logic [LARGURA_CONT-1:0] CONT_MAX = '1;

  logic [LARGURA_DADO-1:0] pc4Q, dado1Q, dado2Q, enderecoQ;
  logic [4:0]              reg2Q, reg3Q, rsQ;
  ctrl_t                   ctrlId, ctrlQ, ctrlD;
  logic                    validoQ, validoD;
  logic [LARGURA_CONT-1:0] bolhasQ, descartesQ;
  logic                    haz;

  assign ctrlId = {idEx.RegDest_ID, idEx.ALUSrc_ID, idEx.MemRead_ID,
                   idEx.MemWrite_ID, idEx.RegWrite_ID, idEx.MemtoReg_ID,
                   idEx.Branch_ID, idEx.ALUOp_ID};

  // Load in EX whose destination is read by the instruction in ID; $0 never hazards.
  assign haz = idEx.valido_ID & ctrlQ.memRead & (reg2Q != 5'd0) &
               ((reg2Q == idEx.rs_ID) | (reg2Q == idEx.rt_ID));
  assign idEx.stall = haz & ~idEx.flush;

  always_comb begin
    ctrlD   = ctrlId;
    validoD = idEx.valido_ID;
    if (idEx.flush || haz || !idEx.valido_ID) begin
      ctrlD   = '0;
      validoD = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc4Q       <= '0;
      dado1Q     <= '0;
      dado2Q     <= '0;
      enderecoQ  <= '0;
      reg2Q      <= '0;
      reg3Q      <= '0;
      rsQ        <= '0;
      ctrlQ      <= '0;
      validoQ    <= 1'b0;
      bolhasQ    <= '0;
      descartesQ <= '0;
    end else begin
      // Data fields always follow ID; only the bubble controls make them don't-care.
      pc4Q      <= idEx.PC4_ID;
      dado1Q    <= idEx.dado1_ID;
      dado2Q    <= idEx.dado2_ID;
      enderecoQ <= idEx.endereco_ID;
      reg2Q     <= idEx.rt_ID;
      reg3Q     <= idEx.rd_ID;
      rsQ       <= idEx.rs_ID;
      ctrlQ     <= ctrlD;
      validoQ   <= validoD;
      if (idEx.flush) begin
        if (descartesQ != CONT_MAX) descartesQ <= descartesQ + 1'b1;
      end else if (haz) begin
        if (bolhasQ != CONT_MAX) bolhasQ <= bolhasQ + 1'b1;
      end
    end
  end

  assign idEx.PC4           = pc4Q;
  assign idEx.dado1ALU      = dado1Q;
  assign idEx.dado2ALU      = dado2Q;
  assign idEx.endereco      = enderecoQ;
  assign idEx.functEx       = enderecoQ[5:0];
  assign idEx.reg2          = reg2Q;
  assign idEx.reg3          = reg3Q;
  assign idEx.rs_EX         = rsQ;
  assign idEx.regDestEx     = ctrlQ.regDest;
  assign idEx.ALUSrc_EX     = ctrlQ.aluSrc;
  assign idEx.MemRead_EX    = ctrlQ.memRead;
  assign idEx.MemWrite_EX   = ctrlQ.memWrite;
  assign idEx.RegWrite_EX   = ctrlQ.regWrite;
  assign idEx.MemtoReg_EX   = ctrlQ.memToReg;
  assign idEx.Branch_EX     = ctrlQ.branch;
  assign idEx.ALUOpEx       = ctrlQ.aluOp;
  assign idEx.valido_EX     = validoQ;
  assign idEx.num_bolhas    = bolhasQ;
  assign idEx.num_descartes = descartesQ;

endmodule

// File: tb/tb_registrador_id_ex.sv
// Directed bench: a default-width instance and a 2-bit-counter instance
// share the same ID stimulus; the narrow one exercises counter saturation.
module tb_registrador_id_ex;
  logic clock, reset;
  int   total = 0, passed = 0;

  logic [31:0] PC4_ID, dado1_ID, dado2_ID, endereco_ID;
  logic [4:0]  rs_ID, rt_ID, rd_ID;
  logic        valido_ID, RegDest_ID, ALUSrc_ID, MemRead_ID, MemWrite_ID;
  logic        RegWrite_ID, MemtoReg_ID, Branch_ID, flush;
  logic [1:0]  ALUOp_ID;

  registrador_id_ex_if #(.LARGURA_DADO(32), .LARGURA_CONT(16)) ifA ();
  registrador_id_ex_if #(.LARGURA_DADO(32), .LARGURA_CONT(2))  ifB ();

  assign ifA.PC4_ID = PC4_ID;           assign ifB.PC4_ID = PC4_ID;
  assign ifA.dado1_ID = dado1_ID;       assign ifB.dado1_ID = dado1_ID;
  assign ifA.dado2_ID = dado2_ID;       assign ifB.dado2_ID = dado2_ID;
  assign ifA.endereco_ID = endereco_ID; assign ifB.endereco_ID = endereco_ID;
  assign ifA.rs_ID = rs_ID;             assign ifB.rs_ID = rs_ID;
  assign ifA.rt_ID = rt_ID;             assign ifB.rt_ID = rt_ID;
  assign ifA.rd_ID = rd_ID;             assign ifB.rd_ID = rd_ID;
  assign ifA.valido_ID = valido_ID;     assign ifB.valido_ID = valido_ID;
  assign ifA.RegDest_ID = RegDest_ID;   assign ifB.RegDest_ID = RegDest_ID;
  assign ifA.ALUSrc_ID = ALUSrc_ID;     assign ifB.ALUSrc_ID = ALUSrc_ID;
  assign ifA.MemRead_ID = MemRead_ID;   assign ifB.MemRead_ID = MemRead_ID;
  assign ifA.MemWrite_ID = MemWrite_ID; assign ifB.MemWrite_ID = MemWrite_ID;
  assign ifA.RegWrite_ID = RegWrite_ID; assign ifB.RegWrite_ID = RegWrite_ID;
  assign ifA.MemtoReg_ID = MemtoReg_ID; assign ifB.MemtoReg_ID = MemtoReg_ID;
  assign ifA.Branch_ID = Branch_ID;     assign ifB.Branch_ID = Branch_ID;
  assign ifA.ALUOp_ID = ALUOp_ID;       assign ifB.ALUOp_ID = ALUOp_ID;
  assign ifA.flush = flush;             assign ifB.flush = flush;

  registrador_id_ex #(.LARGURA_DADO(32), .LARGURA_CONT(16)) dutA (
    .clock(clock), .reset(reset), .idEx(ifA.slave));
  registrador_id_ex #(.LARGURA_DADO(32), .LARGURA_CONT(2)) dutB (
    .clock(clock), .reset(reset), .idEx(ifB.slave));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    PC4_ID = 0; dado1_ID = 0; dado2_ID = 0; endereco_ID = 0;
    rs_ID = 0; rt_ID = 0; rd_ID = 0; valido_ID = 1'b1;
    RegDest_ID = 0; ALUSrc_ID = 0; MemRead_ID = 0; MemWrite_ID = 0;
    RegWrite_ID = 0; MemtoReg_ID = 0; Branch_ID = 0; ALUOp_ID = 2'b00; flush = 0;
  endtask

  task automatic loadWord(input logic [4:0] rt);
    idle(); MemRead_ID = 1; MemtoReg_ID = 1; RegWrite_ID = 1; ALUSrc_ID = 1;
    rs_ID = 5'd1; rt_ID = rt;
  endtask

  task automatic ctrlZero(input string tag);
    chk({tag, "_ctrl"}, {ifA.regDestEx, ifA.ALUSrc_EX, ifA.MemRead_EX, ifA.MemWrite_EX,
        ifA.RegWrite_EX, ifA.MemtoReg_EX, ifA.Branch_EX, ifA.ALUOpEx, ifA.valido_EX}, 0);
  endtask

  initial begin
    // Reset with random ID contents
    reset = 1'b0; idle();
    PC4_ID = $urandom; dado1_ID = $urandom; dado2_ID = $urandom; endereco_ID = $urandom;
    rs_ID = 5'd3; rt_ID = 5'd4; rd_ID = 5'd6; MemRead_ID = 1; RegWrite_ID = 1; ALUOp_ID = 2'b11;
    #2;
    chk("rst_pc4", ifA.PC4, 0);
    chk("rst_dado1", ifA.dado1ALU, 0);
    ctrlZero("rst");
    chk("rst_bolhas", ifA.num_bolhas, 0);
    chk("rst_descartes", ifA.num_descartes, 0);
    chk("rst_stall", ifA.stall, 0);
    step();
    chk("rst_hold_edge", {ifA.PC4, ifA.reg2, ifA.MemRead_EX}, 0);
    reset = 1'b1; #1;
    chk("rst_release_noedge", {ifA.PC4, ifA.endereco, ifA.valido_EX}, 0);

    // Normal capture
    idle(); PC4_ID = 32'h55; dado1_ID = 1; dado2_ID = 1; endereco_ID = 32'h20;
    rs_ID = 5'd1; rt_ID = 5'd2; rd_ID = 5'd3; RegDest_ID = 1; RegWrite_ID = 1;
    step();
    chk("cap_pc4", ifA.PC4, 32'h55);
    chk("cap_dados", {ifA.dado1ALU, ifA.dado2ALU}, {32'h1, 32'h1});
    chk("cap_endereco", ifA.endereco, 32'h20);
    chk("cap_funct", ifA.functEx, 6'b100000);
    chk("cap_regs", {ifA.reg2, ifA.reg3, ifA.rs_EX}, {5'd2, 5'd3, 5'd1});
    chk("cap_ctrl", {ifA.regDestEx, ifA.RegWrite_EX, ifA.MemRead_EX, ifA.ALUOpEx, ifA.valido_EX},
        {1'b1, 1'b1, 1'b0, 2'b00, 1'b1});

    // Invalid ID instruction becomes a bubble, data still flows
    idle(); valido_ID = 0; PC4_ID = 32'h99; RegWrite_ID = 1; MemWrite_ID = 1; Branch_ID = 1;
    ALUOp_ID = 2'b10;
    step();
    chk("inv_pc4", ifA.PC4, 32'h99);
    ctrlZero("inv");
    chk("inv_cnt", {ifA.num_bolhas, ifA.num_descartes}, 0);

    // Load-use on rs: one bubble, then the dependent instruction
    loadWord(5'd8);
    step();
    chk("lw_ex", {ifA.MemRead_EX, ifA.reg2}, {1'b1, 5'd8});
    idle(); rs_ID = 5'd8; rt_ID = 5'd9; rd_ID = 5'd10; RegWrite_ID = 1; RegDest_ID = 1;
    ALUOp_ID = 2'b10; PC4_ID = 32'h100;
    #1;
    chk("lu_stall", ifA.stall, 1);
    step();
    ctrlZero("lu_bubble");
    chk("lu_bolhas", {ifA.num_bolhas, ifB.num_bolhas}, {16'd1, 2'd1});
    chk("lu_stall_drop", ifA.stall, 0);
    step();
    chk("lu_dep", {ifA.PC4, ifA.RegWrite_EX, ifA.ALUOpEx, ifA.valido_EX, ifA.rs_EX},
        {32'h100, 1'b1, 2'b10, 1'b1, 5'd8});
    chk("lu_bolhas_hold", ifA.num_bolhas, 1);

    // $0 destination never hazards
    loadWord(5'd0);
    step();
    idle(); rs_ID = 5'd0; rt_ID = 5'd5; #1;
    chk("zero_stall", ifA.stall, 0);
    // Non-load producer never hazards
    step();
    idle(); rt_ID = 5'd8; RegWrite_ID = 1;
    step();
    idle(); rs_ID = 5'd8; #1;
    chk("nonload_stall", ifA.stall, 0);
    step();
    chk("nohaz_bolhas", ifA.num_bolhas, 1);

    // Hazard via rt; invalid ID suppresses it; flush overrides it
    loadWord(5'd7);
    step();
    idle(); rs_ID = 5'd3; rt_ID = 5'd7; RegWrite_ID = 1; #1;
    chk("rt_stall", ifA.stall, 1);
    valido_ID = 0; #1;
    chk("inv_nostall", ifA.stall, 0);
    valido_ID = 1; flush = 1; #1;
    chk("flush_stall", ifA.stall, 0);
    step();
    ctrlZero("flush_bubble");
    chk("flush_cnt", {ifA.num_descartes, ifA.num_bolhas}, {16'd1, 16'd1});

    // Reset asserted mid-stall
    loadWord(5'd8);
    step();
    idle(); rs_ID = 5'd8; #1;
    chk("mid_stall", ifA.stall, 1);
    reset = 0; #1;
    chk("mid_rst_stall", ifA.stall, 0);
    chk("mid_rst_out", {ifA.MemRead_EX, ifA.reg2, ifA.PC4, ifA.num_bolhas, ifA.num_descartes}, 0);
    @(negedge clock); reset = 1;
    idle(); PC4_ID = 32'h200; rd_ID = 5'd12; RegWrite_ID = 1;
    step();
    chk("mid_resume", {ifA.PC4, ifA.reg3, ifA.RegWrite_EX}, {32'h200, 5'd12, 1'b1});

    // Five hazards: narrow counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      loadWord(5'd8);
      step();
      idle(); rs_ID = 5'd8;
      step();
      chk($sformatf("sat_b_%0d", i), ifB.num_bolhas, (i < 3) ? i + 1 : 3);
      chk($sformatf("sat_a_%0d", i), ifA.num_bolhas, i + 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
